qos_ingress_scheduler: RTL and testbench

Upstream feeder for the transaction layer. Accepts 4-bit data words tagged with a 2-bit traffic class, buffers them in one small FIFO per class, and drives the transaction layer's push interface (`PUSHDATOENTRADA` / `IDINPUT` / `DATO_IN`). It honours the transaction layer's per-class `PAUSE_STB`, `CONTINUE_STB` and `ERROR_FULL` feedback by round-robin scheduling only among classes that are not paused.

---
 rtl/qos_ingress_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_qos_ingress_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/qos_ingress_scheduler.sv
// -----------------------------------------------------------------------------
// qos_ingress_scheduler
//
// Upstream feeder for the transaction layer. Incoming 4-bit words tagged with
// a 2-bit traffic class are buffered in one FIFO per class. A round-robin
// arbiter picks one eligible (non-empty, not paused) class per cycle. The
// popped word passes through one internal stage and is then presented on the
// registered push interface. Write-to-push latency is 2 edges.
//
// Optional feature macro: QOS_INGRESS_DROP_EN
//   defined   : IN_READY tied high. Words offered to a full class are dropped
//               and counted per class in DROP_CNT (8-bit saturating, class i
//               at [8i+7:8i]).
//   undefined : backpressure through IN_READY; DROP_CNT does not exist.
//
// Ports
//   CLOCK, RESET          clock, synchronous active-high reset
//   IN_VALID/IN_ID/IN_DATO source offer (class, data)
//   IN_READY              combinational accept for the class on IN_ID
//   PAUSE_STB/CONTINUE_STB per-class pause / resume strobes
//   ERROR_FULL            per-class overflow: pauses and sets sticky error
//   PUSH_OUT/ID_OUT/DATO_OUT registered push to the transaction layer
//   PAUSED, ERR_STICKY    per-class pause flag and sticky error
//   DROP_CNT              per-class drop counters (drop build only)
//   IDLE_OUT              registered: all FIFOs empty and PUSH_OUT low
// -----------------------------------------------------------------------------

// Per-class FIFO. DEPTH is a power of two, so the pointers wrap naturally.
// Ports: write (wr_i/wdata_i), read (rd_i/rdata_o, first-word fall-through),
// full_o/empty_o of the current state, empty_d_o of the state after this edge.
module qos_class_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rd_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          empty_d_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_i && !rd_i)      cnt_d = cnt_q + CW'(1);
    else if (!wr_i && rd_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_i) wptr_q <= wptr_q + AW'(1);
      if (rd_i) rptr_q <= rptr_q + AW'(1);
    end
  end

  // Storage needs no reset: contents are only visible while cnt_q says so.
  always_ff @(posedge clk_i) begin
    if (wr_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o   = mem_q[rptr_q];
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign empty_d_o = (cnt_d == '0);
endmodule

module qos_ingress_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        IN_VALID,
  input  logic [1:0]  IN_ID,
  input  logic [3:0]  IN_DATO,
  output logic        IN_READY,
  input  logic [3:0]  PAUSE_STB,
  input  logic [3:0]  CONTINUE_STB,
  input  logic [3:0]  ERROR_FULL,
  output logic        PUSH_OUT,
  output logic [1:0]  ID_OUT,
  output logic [3:0]  DATO_OUT,
  output logic [3:0]  PAUSED,
  output logic [3:0]  ERR_STICKY,
`ifdef QOS_INGRESS_DROP_EN
  output logic [31:0] DROP_CNT,
`endif
  output logic        IDLE_OUT
);
  localparam int NC     = 4;
  localparam int DW     = 4;
  localparam int STAGES = 2;

  logic [NC-1:0]         full, empty, empty_d, wr, pop, elig;
  logic [NC-1:0][DW-1:0] rdata;
  logic [NC-1:0]         paused_q, paused_d, err_q;
  logic [1:0]            rr_q, rr_d, gnt_id, idx;
  logic                  gnt_vld;
  logic                  room, accept;

  // vld_pipe_q[1]: word popped last edge, held in stage 1.
  // vld_pipe_q[2]: PUSH_OUT.
  logic [STAGES:1]       vld_pipe_q;
  logic [1:0]            s1_id_q, id_q;
  logic [DW-1:0]         s1_dat_q, dat_q;
  logic                  idle_q, idle_d;

  // A full class still has room when it is popped this same cycle.
  assign room   = !full[IN_ID] || pop[IN_ID];
  assign accept = IN_VALID && room;

`ifdef QOS_INGRESS_DROP_EN
  assign IN_READY = 1'b1;
`else
  assign IN_READY = room;
`endif

  generate
    for (genvar c = 0; c < NC; c++) begin : g_cls
      qos_class_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk_i    (CLOCK),
        .rst_i    (RESET),
        .wr_i     (wr[c]),
        .wdata_i  (IN_DATO),
        .rd_i     (pop[c]),
        .rdata_o  (rdata[c]),
        .full_o   (full[c]),
        .empty_o  (empty[c]),
        .empty_d_o(empty_d[c])
      );
      assign wr[c]  = accept && (IN_ID == 2'(c));
      assign pop[c] = gnt_vld && (gnt_id == 2'(c));
    end
  endgenerate

  // Eligibility uses the registered pause flag only, so a strobe affects
  // grants from the following cycle.
  assign elig = ~empty & ~paused_q;

  // Round-robin: search rr, rr+1, rr+2, rr+3; the first eligible class wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = rr_q;
    idx     = rr_q;
    for (int k = 0; k < NC; k++) begin
      idx = rr_q + 2'(k);
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
    rr_d = gnt_vld ? (gnt_id + 2'd1) : rr_q;
  end

  // Set (pause or overflow) wins over a same-cycle continue.
  assign paused_d = (paused_q & ~CONTINUE_STB) | PAUSE_STB | ERROR_FULL;

  // Next PUSH_OUT is whatever sits in stage 1 now.
  assign idle_d = (&empty_d) && !vld_pipe_q[1];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      vld_pipe_q <= '0;
      s1_id_q    <= '0;
      s1_dat_q   <= '0;
      id_q       <= '0;
      dat_q      <= '0;
      rr_q       <= '0;
      paused_q   <= '0;
      err_q      <= '0;
      idle_q     <= 1'b1;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], gnt_vld};
      rr_q       <= rr_d;
      if (gnt_vld) begin
        s1_id_q  <= gnt_id;
        s1_dat_q <= rdata[gnt_id];
      end
      // ID/DATO hold their last values when no push is issued.
      if (vld_pipe_q[1]) begin
        id_q  <= s1_id_q;
        dat_q <= s1_dat_q;
      end
      paused_q <= paused_d;
      err_q    <= err_q | ERROR_FULL;
      idle_q   <= idle_d;
    end
  end

`ifdef QOS_INGRESS_DROP_EN
  logic [NC-1:0][7:0] drop_cnt_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      drop_cnt_q <= '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (IN_VALID && (IN_ID == 2'(c)) && full[c] && !pop[c] &&
            (drop_cnt_q[c] != 8'hFF))
          drop_cnt_q[c] <= drop_cnt_q[c] + 8'd1;
      end
    end
  end

  assign DROP_CNT = drop_cnt_q;
`endif

  assign PUSH_OUT   = vld_pipe_q[STAGES];
  assign ID_OUT     = id_q;
  assign DATO_OUT   = dat_q;
  assign PAUSED     = paused_q;
  assign ERR_STICKY = err_q;
  assign IDLE_OUT   = idle_q;
endmodule

// File: tb/tb_qos_ingress_scheduler.sv
// Directed bench for qos_ingress_scheduler (DEPTH = 4). Inputs change 1 time
// unit after a rising edge; outputs are sampled at the same point.
module tb_qos_ingress_scheduler;
  logic        clk = 1'b0;
  logic        RESET;
  logic        IN_VALID;
  logic [1:0]  IN_ID;
  logic [3:0]  IN_DATO;
  logic        IN_READY;
  logic [3:0]  PAUSE_STB, CONTINUE_STB, ERROR_FULL;
  logic        PUSH_OUT;
  logic [1:0]  ID_OUT;
  logic [3:0]  DATO_OUT;
  logic [3:0]  PAUSED, ERR_STICKY;
  logic        IDLE_OUT;
`ifdef QOS_INGRESS_DROP_EN
  logic [31:0] DROP_CNT;
`endif

  int checks = 0;
  int errors = 0;

  qos_ingress_scheduler #(.DEPTH(4)) dut (
    .CLOCK       (clk),
    .RESET       (RESET),
    .IN_VALID    (IN_VALID),
    .IN_ID       (IN_ID),
    .IN_DATO     (IN_DATO),
    .IN_READY    (IN_READY),
    .PAUSE_STB   (PAUSE_STB),
    .CONTINUE_STB(CONTINUE_STB),
    .ERROR_FULL  (ERROR_FULL),
    .PUSH_OUT    (PUSH_OUT),
    .ID_OUT      (ID_OUT),
    .DATO_OUT    (DATO_OUT),
    .PAUSED      (PAUSED),
    .ERR_STICKY  (ERR_STICKY),
`ifdef QOS_INGRESS_DROP_EN
    .DROP_CNT    (DROP_CNT),
`endif
    .IDLE_OUT    (IDLE_OUT)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_push(input string tag, input int id, input int dat);
    check({tag, ".push"}, 32'(PUSH_OUT), 1);
    check({tag, ".id"},   32'(ID_OUT),   32'(id));
    check({tag, ".dato"}, 32'(DATO_OUT), 32'(dat));
  endtask

  initial begin
    RESET = 1'b1; IN_VALID = 1'b0; IN_ID = '0; IN_DATO = '0;
    PAUSE_STB = '0; CONTINUE_STB = '0; ERROR_FULL = '0;

    // ---- reset state
    tick(); tick();
    check("rst.push",   32'(PUSH_OUT),   0);
    check("rst.id",     32'(ID_OUT),     0);
    check("rst.dato",   32'(DATO_OUT),   0);
    check("rst.paused", 32'(PAUSED),     0);
    check("rst.err",    32'(ERR_STICKY), 0);
    check("rst.idle",   32'(IDLE_OUT),   1);
    check("rst.ready",  32'(IN_READY),   1);

    // ---- single word, class 2, 0xA written at edge 1
    RESET = 1'b0; IN_VALID = 1'b1; IN_ID = 2'd2; IN_DATO = 4'hA;
    tick();                                   // edge 1
    IN_VALID = 1'b0;
    check("one.e1.push", 32'(PUSH_OUT), 0);
    check("one.e1.idle", 32'(IDLE_OUT), 0);
    tick();                                   // edge 2
    check("one.e2.push", 32'(PUSH_OUT), 0);
    tick();                                   // edge 3
    check_push("one.e3", 2, 'hA);
    check("one.e3.idle", 32'(IDLE_OUT), 0);
    tick();                                   // edge 4
    check("one.e4.push", 32'(PUSH_OUT), 0);
    check("one.e4.idle", 32'(IDLE_OUT), 1);
    check("one.e4.idhold", 32'(ID_OUT), 2);
    check("one.e4.dhold",  32'(DATO_OUT), 'hA);

    // ---- fill all classes (2 words each) while paused, then release
    RESET = 1'b1; tick(); RESET = 1'b0;       // rr back to 0
    PAUSE_STB = 4'hF;
    for (int i = 0; i < 8; i++) begin
      IN_VALID = 1'b1; IN_ID = 2'(i % 4); IN_DATO = 4'(2 * (i % 4) + i / 4 + 1);
      check("fill.ready", 32'(IN_READY), 1);
      tick();
      PAUSE_STB = '0;
    end
    IN_VALID = 1'b0;
    check("fill.paused", 32'(PAUSED), 'hF);
    check("fill.push",   32'(PUSH_OUT), 0);
    CONTINUE_STB = 4'hF;
    tick();
    CONTINUE_STB = '0;
    check("fill.cont.paused", 32'(PAUSED), 0);
    tick();
    check("fill.lat.push", 32'(PUSH_OUT), 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_push($sformatf("rr%0d", k), k % 4, 2 * (k % 4) + k / 4 + 1);
    end
    tick();
    check("fill.end.push", 32'(PUSH_OUT), 0);
    check("fill.end.idle", 32'(IDLE_OUT), 1);

    // ---- pause class 1 while it is continuously fed
    IN_VALID = 1'b1; IN_ID = 2'd1;
    IN_DATO = 4'd9;  tick(); check("p.a0.push", 32'(PUSH_OUT), 0);
    IN_DATO = 4'd10; tick(); check("p.a1.push", 32'(PUSH_OUT), 0);
    IN_DATO = 4'd11; tick(); check_push("p.a2", 1, 9);
    IN_DATO = 4'd12; PAUSE_STB = 4'b0010;
    tick();                                   // strobe edge
    PAUSE_STB = '0;
    check_push("p.a3", 1, 10);                // already in flight
    check("p.a3.paused", 32'(PAUSED), 'b0010);
    IN_DATO = 4'd13; tick(); check_push("p.a4", 1, 11);  // the one further push
    IN_DATO = 4'd14; tick(); check("p.a5.push", 32'(PUSH_OUT), 0);
    IN_DATO = 4'd15; tick(); check("p.a6.push", 32'(PUSH_OUT), 0);
    IN_DATO = 4'd0; #1;
`ifndef QOS_INGRESS_DROP_EN
    check("p.full.ready", 32'(IN_READY), 0);
`endif
    IN_ID = 2'd0; IN_DATO = 4'd3; #1;
    check("p.c0.ready", 32'(IN_READY), 1);
    tick(); check("p.b0.push", 32'(PUSH_OUT), 0);
    IN_ID = 2'd2; IN_DATO = 4'd5;
    tick(); check("p.b1.push", 32'(PUSH_OUT), 0);
    IN_VALID = 1'b0;
    tick(); check_push("p.b2", 0, 3);
    tick(); check_push("p.b3", 2, 5);
    tick(); check("p.b4.push", 32'(PUSH_OUT), 0);
    CONTINUE_STB = 4'b0010;
    tick();                                   // continue edge E
    CONTINUE_STB = '0;
    check("p.e0.push",   32'(PUSH_OUT), 0);
    check("p.e0.paused", 32'(PAUSED), 0);
    tick(); check("p.e1.push", 32'(PUSH_OUT), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_push($sformatf("p.resume%0d", k), 1, 12 + k);
    end
    tick(); check("p.end.push", 32'(PUSH_OUT), 0);

    // ---- pause/continue collision, sticky error
    PAUSE_STB = 4'b1000; CONTINUE_STB = 4'b1000;
    tick();
    PAUSE_STB = '0; CONTINUE_STB = '0;
    check("coll.paused", 32'(PAUSED), 'b1000);
    ERROR_FULL = 4'b0001;
    tick();
    ERROR_FULL = '0;
    check("errf.paused", 32'(PAUSED), 'b1001);
    check("errf.sticky", 32'(ERR_STICKY), 'b0001);
    CONTINUE_STB = 4'b1001;
    tick();
    CONTINUE_STB = '0;
    check("errc.paused", 32'(PAUSED), 0);
    check("errc.sticky", 32'(ERR_STICKY), 'b0001);

    // ---- overfill a paused class (DEPTH = 4)
    PAUSE_STB = 4'b0001;
    tick();
    PAUSE_STB = '0;
    check("ovf.paused", 32'(PAUSED), 'b0001);
    for (int i = 0; i < 6; i++) begin
      IN_VALID = 1'b1; IN_ID = 2'd0; IN_DATO = 4'(i + 1);
      #1;
`ifdef QOS_INGRESS_DROP_EN
      check($sformatf("ovf.ready%0d", i), 32'(IN_READY), 1);
`else
      check($sformatf("ovf.ready%0d", i), 32'(IN_READY), (i < 4) ? 1 : 0);
`endif
      tick();
    end
    IN_VALID = 1'b0;
`ifdef QOS_INGRESS_DROP_EN
    check("ovf.dropcnt", DROP_CNT, 2);
`endif
    CONTINUE_STB = 4'b0001;
    tick();
    CONTINUE_STB = '0;
    tick(); check("ovf.lat.push", 32'(PUSH_OUT), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_push($sformatf("ovf.drain%0d", k), 0, k + 1);
    end
    tick(); check("ovf.end.push", 32'(PUSH_OUT), 0);

    // ---- reset mid-stream: 3 queued plus one in flight
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1; IN_ID = 2'd3; IN_DATO = 4'(i + 9);
      PAUSE_STB = (i == 0) ? 4'b1000 : 4'b0000;
      tick();
      check("mid.fill.push", 32'(PUSH_OUT), 0);
    end
    IN_VALID = 1'b0; PAUSE_STB = '0; CONTINUE_STB = 4'b1000;
    tick();
    CONTINUE_STB = '0;
    check("mid.c.push", 32'(PUSH_OUT), 0);
    tick();                                   // first word now in stage 1
    check("mid.s1.push", 32'(PUSH_OUT), 0);
    RESET = 1'b1;
    tick();
    check("mid.rst.push",   32'(PUSH_OUT),   0);
    check("mid.rst.idle",   32'(IDLE_OUT),   1);
    check("mid.rst.sticky", 32'(ERR_STICKY), 0);
    check("mid.rst.id",     32'(ID_OUT),     0);
    check("mid.rst.dato",   32'(DATO_OUT),   0);
    RESET = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("mid.post%0d.push", k), 32'(PUSH_OUT), 0);
    end
    check("mid.post.idle", 32'(IDLE_OUT), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
